// File: rtl/vga_term_writer.sv
// Turns an ASCII byte stream into character-memory writes for a COLS x ROWS text terminal.
// Every output is registered; each write appears on the cycle after it is decided.
module vga_term_writer #(
  parameter int COLS = 71,
  parameter int ROWS = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic [2:0]  fg,
  input  logic [2:0]  bg,
  output logic        sel,
  output logic        we,
  output logic [31:0] addr,
  output logic [31:0] din,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR_ROW, CLEAR_SCREEN} state_t;

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [7:0] SPACE    = 8'h20;

  state_t     state, state_n;
  logic [4:0] row, row_n, a_row, a_row_n, nrow;
  logic [6:0] col, col_n, a_col, a_col_n;
  logic [7:0] chr, chr_n;
  logic [2:0] fg_q, fg_n, bg_q, bg_n;
  logic       wr, wr_n, adv, adv_n, accept;

  assign nrow   = (row == LAST_ROW) ? 5'd0 : row + 5'd1;
  assign accept = in_valid && in_ready;

  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    a_row_n = a_row;
    a_col_n = a_col;
    chr_n   = chr;
    fg_n    = fg_q;
    bg_n    = bg_q;
    adv_n   = adv;
    wr_n    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          fg_n = fg;
          bg_n = bg;
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            state_n = WRITE;
            wr_n    = 1'b1;
            a_row_n = row;
            a_col_n = col;
            chr_n   = in_data;
            adv_n   = 1'b1;
          end else if (in_data == 8'h0A) begin
            state_n = CLEAR_ROW;
            wr_n    = 1'b1;
            row_n   = nrow;
            col_n   = 7'd0;
            a_row_n = nrow;
            a_col_n = 7'd0;
            chr_n   = SPACE;
          end else if (in_data == 8'h0D) begin
            col_n = 7'd0;
          end else if (in_data == 8'h08 && col != 7'd0) begin
            // Backspace erases in place; the cursor is not advanced afterwards.
            state_n = WRITE;
            wr_n    = 1'b1;
            col_n   = col - 7'd1;
            a_row_n = row;
            a_col_n = col - 7'd1;
            chr_n   = SPACE;
            adv_n   = 1'b0;
          end else if (in_data == 8'h0C) begin
            state_n = CLEAR_SCREEN;
            wr_n    = 1'b1;
            row_n   = 5'd0;
            col_n   = 7'd0;
            a_row_n = 5'd0;
            a_col_n = 7'd0;
            chr_n   = SPACE;
          end
        end
      end
      WRITE: begin
        state_n = IDLE;
        if (adv) begin
          if (col != LAST_COL) begin
            col_n = col + 7'd1;
          end else begin
            state_n = CLEAR_ROW;
            wr_n    = 1'b1;
            col_n   = 7'd0;
            row_n   = nrow;
            a_row_n = nrow;
            a_col_n = 7'd0;
            chr_n   = SPACE;
          end
        end
      end
      CLEAR_ROW: begin
        // The write address doubles as the sweep counter.
        if (a_col != LAST_COL) begin
          wr_n    = 1'b1;
          a_col_n = a_col + 7'd1;
        end else begin
          state_n = IDLE;
        end
      end
      CLEAR_SCREEN: begin
        if (a_col != LAST_COL) begin
          wr_n    = 1'b1;
          a_col_n = a_col + 7'd1;
        end else if (a_row != LAST_ROW) begin
          wr_n    = 1'b1;
          a_col_n = 7'd0;
          a_row_n = a_row + 5'd1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      row      <= 5'd0;
      col      <= 7'd0;
      a_row    <= 5'd0;
      a_col    <= 7'd0;
      chr      <= 8'd0;
      fg_q     <= 3'd0;
      bg_q     <= 3'd0;
      adv      <= 1'b0;
      wr       <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      row      <= row_n;
      col      <= col_n;
      a_row    <= a_row_n;
      a_col    <= a_col_n;
      chr      <= chr_n;
      fg_q     <= fg_n;
      bg_q     <= bg_n;
      adv      <= adv_n;
      wr       <= wr_n;
      in_ready <= (state_n == IDLE);
      busy     <= (state_n != IDLE);
    end
  end

  assign sel        = wr;
  assign we         = wr;
  assign addr       = {19'd0, a_col, a_row, 1'b0};
  assign din        = {18'd0, bg_q, fg_q, chr};
  assign cursor_row = row;
  assign cursor_col = col;

endmodule

// File: doc/vga_term_writer.md
VGA_TERM_WRITER -- requirements
Module: vga_term_writer

Interface
REQ-001 Parameter COLS, default 71, text columns per row; column addresses run 0..COLS-1.
REQ-002 Parameter ROWS, default 30, text rows; row addresses run 0..ROWS-1.
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  byte-stream valid.
REQ-006 in_data  in  8  ASCII byte.
REQ-007 in_ready  out  1  writer can accept a byte this cycle.
REQ-008 fg  in  3  foreground color, sampled on byte acceptance.
REQ-009 bg  in  3  background color, sampled on byte acceptance.
REQ-010 sel  out  1  character-memory select.
REQ-011 we  out  1  character-memory write enable; equals sel.
REQ-012 addr  out  32  write address: [12:6] column, [5:1] row, all other bits 0.
REQ-013 din  out  32  write data: [7:0] ASCII, [10:8] fg, [13:11] bg, [31:14] 0.
REQ-014 cursor_row  out  5  current cursor row.
REQ-015 cursor_col  out  7  current cursor column.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 Handshake: a byte is accepted on a rising edge where in_valid=1 and in_ready=1; in_ready=1 only in IDLE.
REQ-018 States: IDLE, WRITE, CLEAR_ROW, CLEAR_SCREEN; every output is registered.
REQ-019 Printable byte (0x20..0x7E): go to WRITE; the next cycle drives sel=we=1 for exactly one cycle at the pre-acceptance cursor with {bg,fg,byte}; the column then advances.
REQ-020 Column advance: col<COLS-1 -> col+1, return to IDLE; col=COLS-1 -> col=0, row advances.
REQ-021 Row advance: row<ROWS-1 -> row+1; row=ROWS-1 -> row=0; every row advance enters CLEAR_ROW.
REQ-022 CLEAR_ROW: writes 0x20 with the sampled colors to columns 0..COLS-1 of the new row, one write per cycle in ascending order (COLS cycles), then IDLE.
REQ-023 0x0A: col=0 and row advances (CLEAR_ROW); no character write.
REQ-024 0x0D: col=0 on the acceptance edge; stay in IDLE; no write.
REQ-025 0x08: if col>0, col-1 and WRITE a 0x20 at the new column with no further advance; if col=0, no effect and stay in IDLE.
REQ-026 0x0C: CLEAR_SCREEN writes 0x20 to all ROWS*COLS cells, row-major from (0,0), one per cycle; cursor=(0,0) at exit; then IDLE.
REQ-027 Any other byte (including 0x7F and >=0x80): consumed with no write and no cursor change; stay in IDLE.
REQ-028 sel=we=0 in IDLE and on every cycle without a write; one write per cycle maximum.
REQ-029 fg/bg changes while busy do not affect the writes in progress.
REQ-030 Throughput: one printable byte per 2 cycles without row advance.

Reset
REQ-031 reset=0 forces IDLE immediately, including mid-WRITE or mid-clear; clear progress is abandoned and not resumed.
REQ-032 Reset values: sel=0, we=0, addr=0, din=0, cursor_row=0, cursor_col=0, busy=0; in_ready=1 from the first edge after reset deasserts.

Verification
REQ-033 After reset, send 'A' (0x41) with fg=7, bg=1 -> one cycle of sel=we=1, addr=0x0, din=0x0F41; cursor (0,1); in_ready low for exactly 1 cycle.
REQ-034 With the cursor at (0,70), send 'Z' -> write at addr=(70<<6)=0x1180; then 71 space writes to row 1 (addr=0x2 + (c<<6), c=0..70); cursor (1,0).
REQ-035 With the cursor at (29,5), send 0x0A -> no character write; row 0 cleared (71 writes); cursor (0,0).
REQ-036 Send 0x0C -> exactly 2130 writes, all din[7:0]=0x20, last write at addr=(70<<6)|(29<<1); busy for 2130 cycles; cursor (0,0).
REQ-037 With the cursor at (3,0), send 0x08 -> no write, no change; at (3,4), send 0x08 -> space written at (3,3), cursor (3,3).
REQ-038 Assert reset=0 during CLEAR_SCREEN -> sel, we and busy drop immediately; cursor (0,0); after release, the next 'B' writes at addr=0.
